// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq -- sequenced per-channel reset release controller.
//
// After the asynchronous reset is released, and after a synchroniser has
// settled, all channel resets are held asserted for HOLD_CYC cycles. The
// channels are then released one at a time, in index order. Each channel
// waits for its ready acknowledge before the next channel is released.
//
// Optional feature (macro RST_SEQ_TIMEOUT_EN):
//   - When the macro is defined, each per-channel wait is bounded to
//     TIMEOUT_CYC cycles.
//   - An expired wait sets the sticky o_timeout_err flag and advances the
//     sequence.
//   - When the macro is undefined, each wait is unbounded and o_timeout_err
//     is tied to 0.
//
// Ports:
//   i_in_clk       clock
//   i_rst_async_n  asynchronous active-low reset (release is synchronised)
//   i_soft_rst     synchronous active-high soft reset request (level)
//   i_ch_rdy       per-channel "out of reset, ready" acknowledge
//   o_rst_sync     registered active-high reset per channel
//   o_all_rel      all channels released and acknowledged
//   o_cur_ch       index of the channel currently being released
//   o_timeout_err  sticky: a channel's ready timed out
// -----------------------------------------------------------------------------
module rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_CYC    = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                           i_in_clk,
  input  logic                                           i_rst_async_n,
  input  logic                                           i_soft_rst,
  input  logic [NUM_CH-1:0]                              i_ch_rdy,
  output logic [NUM_CH-1:0]                              o_rst_sync,
  output logic                                           o_all_rel,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_cur_ch,
  output logic                                           o_timeout_err
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYC) + 1;

  // The counter reaches HOLD_CYC-1 on the same edge that the FSM leaves
  // S_HOLD. The transition is therefore taken while the counter still
  // holds HOLD_CYC-2.
  localparam logic [HOLD_W-1:0] HOLD_LAST_M1 =
      (HOLD_CYC >= 2) ? HOLD_W'(HOLD_CYC - 2) : {HOLD_W{1'b0}};
  localparam logic [CH_W-1:0]   LAST_CH      = CH_W'(NUM_CH - 1);

  // An out-of-range parameter elaborates a visibly named block.
  if (NUM_CH < 1 || NUM_CH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 8 ||
      HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_illegal_params
    logic illegal_params_s;
    assign illegal_params_s = 1'b1;
  end

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_done_s;
  state_t                 state_r, state_s;
  logic [HOLD_W-1:0]      hold_cnt_r, hold_cnt_s;
  logic [NUM_CH-1:0]      rst_sync_r, rst_sync_s;
  logic                   all_rel_r, all_rel_s;
  logic [CH_W-1:0]        cur_ch_r, cur_ch_s;
  logic                   rdy_s;
  logic                   to_hit_s;

`ifdef RST_SEQ_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_r, to_cnt_s;
  logic            timeout_err_r, timeout_err_s;
`endif

  // Reset-release synchroniser: cleared asynchronously, shifts in ones.
  always_ff @(posedge i_in_clk or negedge i_rst_async_n) begin
    if (!i_rst_async_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_done_s = sync_r[SYNC_STAGES-1];

  // Timeout detection: true on the last allowed cycle of a channel wait.
  always_comb begin
    to_hit_s = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    if (to_cnt_r == TO_LAST) begin
      to_hit_s = 1'b1;
    end else begin
      to_hit_s = 1'b0;
    end
`endif
  end

  // Next-state and next-output logic.
  // Soft reset and an unsettled synchroniser override every state.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    rst_sync_s = rst_sync_r;
    all_rel_s  = all_rel_r;
    cur_ch_s   = cur_ch_r;
`ifdef RST_SEQ_TIMEOUT_EN
    to_cnt_s      = to_cnt_r;
    timeout_err_s = timeout_err_r;
`endif
    rdy_s = i_ch_rdy[cur_ch_r];

    if (!sync_done_s || i_soft_rst) begin
      state_s    = S_HOLD;
      hold_cnt_s = {HOLD_W{1'b0}};
      rst_sync_s = {NUM_CH{1'b1}};
      all_rel_s  = 1'b0;
      cur_ch_s   = {CH_W{1'b0}};
`ifdef RST_SEQ_TIMEOUT_EN
      to_cnt_s      = {TO_W{1'b0}};
      timeout_err_s = 1'b0;
`endif
    end else begin
      case (state_r)
        S_HOLD: begin
          rst_sync_s = {NUM_CH{1'b1}};
          cur_ch_s   = {CH_W{1'b0}};
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
          if (hold_cnt_r >= HOLD_LAST_M1) begin
            state_s = S_REL;
          end else begin
            state_s = S_HOLD;
          end
        end
        S_REL: begin
          rst_sync_s[cur_ch_r] = 1'b0;
          state_s              = S_WAIT;
`ifdef RST_SEQ_TIMEOUT_EN
          to_cnt_s = {TO_W{1'b0}};
`endif
        end
        S_WAIT: begin
          // An expired timeout advances exactly as if ready had been seen.
          if (rdy_s || to_hit_s) begin
`ifdef RST_SEQ_TIMEOUT_EN
            to_cnt_s = {TO_W{1'b0}};
            if (!rdy_s) begin
              timeout_err_s = 1'b1;
            end else begin
              timeout_err_s = timeout_err_r;
            end
`endif
            if (cur_ch_r == LAST_CH) begin
              state_s   = S_DONE;
              all_rel_s = 1'b1;
            end else begin
              // The next channel is released on the same edge, with no gap.
              cur_ch_s             = cur_ch_r + CH_W'(1);
              rst_sync_s[cur_ch_s] = 1'b0;
              state_s              = S_WAIT;
            end
          end else begin
`ifdef RST_SEQ_TIMEOUT_EN
            to_cnt_s = to_cnt_r + TO_W'(1);
`endif
            state_s = S_WAIT;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        default: begin
          state_s    = S_HOLD;
          hold_cnt_s = {HOLD_W{1'b0}};
          rst_sync_s = {NUM_CH{1'b1}};
          all_rel_s  = 1'b0;
          cur_ch_s   = {CH_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_in_clk or negedge i_rst_async_n) begin
    if (!i_rst_async_n) begin
      state_r    <= S_HOLD;
      hold_cnt_r <= {HOLD_W{1'b0}};
      rst_sync_r <= {NUM_CH{1'b1}};
      all_rel_r  <= 1'b0;
      cur_ch_r   <= {CH_W{1'b0}};
`ifdef RST_SEQ_TIMEOUT_EN
      to_cnt_r      <= {TO_W{1'b0}};
      timeout_err_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      rst_sync_r <= rst_sync_s;
      all_rel_r  <= all_rel_s;
      cur_ch_r   <= cur_ch_s;
`ifdef RST_SEQ_TIMEOUT_EN
      to_cnt_r      <= to_cnt_s;
      timeout_err_r <= timeout_err_s;
`endif
    end
  end

  assign o_rst_sync = rst_sync_r;
  assign o_all_rel  = all_rel_r;
  assign o_cur_ch   = cur_ch_r;
`ifdef RST_SEQ_TIMEOUT_EN
  assign o_timeout_err = timeout_err_r;
`else
  assign o_timeout_err = 1'b0;
`endif

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_CH, default 4, SHALL set the number of reset channels (legal range 1..16).
REQ-003 Parameter SYNC_STAGES, default 3, SHALL set the reset-release synchroniser depth (legal range 2..8).
REQ-004 Parameter HOLD_CYC, default 16, SHALL set the minimum number of all-channels-asserted cycles after reset release (legal minimum 1).
REQ-005 Parameter TIMEOUT_CYC, default 1024, SHALL set the number of cycles to wait for each per-channel ready.
REQ-006 Port i_in_clk, input, 1 bit: clock.
REQ-007 Port i_rst_async_n, input, 1 bit: asynchronous active-low reset, with assertion asynchronous and release synchronised.
REQ-008 Port i_soft_rst, input, 1 bit: synchronous active-high soft reset request (level).
REQ-009 Port i_ch_rdy, input, NUM_CH bits: per-channel "out of reset, ready" acknowledge.
REQ-010 Port o_rst_sync, output, NUM_CH bits: active-high registered reset per channel.
REQ-011 Port o_all_rel, output, 1 bit: all channels released and acknowledged.
REQ-012 Port o_cur_ch, output, $clog2(NUM_CH) bits (minimum 1): index of the channel currently being released.
REQ-013 Port o_timeout_err, output, 1 bit: sticky flag indicating that a channel's ready timed out.

Function
REQ-014 The synchroniser SHALL consist of SYNC_STAGES flops, asynchronously cleared to 0 and shifting in 1; internal reset SHALL remain active until the last stage reads 1.
REQ-015 The FSM SHALL have the states S_HOLD, S_REL, S_WAIT and S_DONE.
REQ-016 S_HOLD behaviour:
- all o_rst_sync bits are 1;
- the hold counter increments each cycle;
- the FSM moves to S_REL when the counter reaches HOLD_CYC-1, with o_cur_ch=0.
REQ-017 In S_REL, o_rst_sync[o_cur_ch] SHALL clear and the FSM SHALL enter S_WAIT with the timeout counter set to 0.
REQ-018 S_WAIT behaviour:
- The FSM samples i_ch_rdy[o_cur_ch].
- When the sampled value is 1 and o_cur_ch<NUM_CH-1: o_cur_ch increments, and o_rst_sync of the new channel clears on the same edge.
- When the sampled value is 1 and o_cur_ch=NUM_CH-1: the FSM moves to S_DONE and o_all_rel is set.
REQ-019 i_ch_rdy bits of channels other than o_cur_ch, and all i_ch_rdy bits outside S_WAIT, SHALL be ignored.
REQ-020 Once released, a channel SHALL remain deasserted until a soft or hard reset, even if its ready later drops.
REQ-021 Latency: o_rst_sync[0] SHALL fall at rising edge SYNC_STAGES+HOLD_CYC, counted from the first edge that samples i_rst_async_n=1 (tolerance ±1 edge for metastability).
REQ-022 Latency: each o_rst_sync[k+1] (k<NUM_CH-1) SHALL fall at the edge that samples i_ch_rdy[k]=1, i.e. with zero added cycles.
REQ-023 When i_soft_rst=1 is sampled in any state, at the next edge all o_rst_sync bits SHALL become 1, o_all_rel SHALL become 0, o_cur_ch SHALL become 0, o_timeout_err SHALL clear, and the FSM SHALL enter S_HOLD with the hold counter at 0.
REQ-024 While i_soft_rst stays 1, the block SHALL remain in S_HOLD with the hold counter held at 0.
REQ-025 i_soft_rst SHALL take priority over a simultaneous i_ch_rdy assertion or timeout.
REQ-026 With NUM_CH=1, the block SHALL go S_REL -> S_WAIT -> S_DONE on ready, and o_cur_ch SHALL be constant 0.

Reset
REQ-027 Asserting i_rst_async_n=0 SHALL, without a clock, force:
- o_rst_sync to all ones;
- o_all_rel, o_cur_ch and o_timeout_err to 0;
- the FSM to S_HOLD;
- all counters and synchroniser flops to 0.
REQ-028 Hard reset asserted mid-sequence, including in S_DONE, SHALL discard all progress, and the full sequence SHALL restart after release.

Configuration
REQ-029 With macro RST_SEQ_TIMEOUT_EN defined, S_WAIT SHALL count cycles; on reaching TIMEOUT_CYC-1 without ready, the block SHALL:
- set o_timeout_err (sticky);
- advance exactly as if ready had been seen.
REQ-030 Without RST_SEQ_TIMEOUT_EN, the block SHALL have no timeout counter, S_WAIT SHALL wait indefinitely, and o_timeout_err SHALL be tied to 0.

Verification
REQ-031 Bench parameters for all scenarios: NUM_CH=4, SYNC_STAGES=3, HOLD_CYC=16, TIMEOUT_CYC=32.
REQ-032 Power-on release scenario: i_ch_rdy=4'hF held, i_rst_async_n released -> o_rst_sync[0] falls at edge 19±1, bits 1..3 fall on the following edges 20, 21, 22 (±1, one per edge), and o_all_rel=1 at edge 23.
REQ-033 Staggered ready scenario: i_ch_rdy[1] raised 10 cycles after o_rst_sync[1] falls -> o_rst_sync[2] falls at that sampling edge, and no channel is released out of order.
REQ-034 Timeout scenario (RST_SEQ_TIMEOUT_EN defined): i_ch_rdy[2] held 0 -> after 32 cycles in S_WAIT, o_timeout_err=1, o_rst_sync[3] falls, and the flag persists in S_DONE.
REQ-035 Soft reset scenario: i_soft_rst pulsed for 5 cycles in S_WAIT on channel 2, coincident with i_ch_rdy[2]=1 -> o_rst_sync=4'hF on the next edge, channel 3 is not released, and o_rst_sync[0] falls 16 edges after i_soft_rst drops.
REQ-036 Hard reset mid-operation scenario: i_rst_async_n driven 0 between clock edges while in S_DONE -> o_rst_sync=4'hF and o_all_rel=0 immediately (asynchronously), and the full 19-edge sequence repeats after release.
